// File: rtl/mips_mem_arbiter.sv
// Shares one single-port memory between the MIPS fetch and data ports: FETCH, optional DATA, then a one-cycle RUN commit pulse.
// Build macro ARB_TIMEOUT_EN bounds consecutive waitrequest cycles (WAIT_LIMIT) and raises a sticky fault.
module mips_mem_arbiter #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        active,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic [31:0] data_address,
  input  logic        data_write,
  input  logic        data_read,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        clk_enable,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic        fault
);

  typedef enum logic [1:0] {FETCH, DATA, RUN, HALT} state_t;

  state_t state, state_nxt;
  logic   busy_abort;
  logic   in_xfer;

  assign in_xfer = (state == FETCH) || (state == DATA);

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(WAIT_LIMIT + 1);

  logic [CW-1:0] wait_cnt;
  logic          fault_q;

  assign busy_abort = in_xfer && mem_waitrequest && (wait_cnt == CW'(WAIT_LIMIT - 1));
  assign fault      = fault_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      fault_q  <= 1'b0;
    end else begin
      if (state_nxt != state)
        wait_cnt <= '0;
      else if (in_xfer && mem_waitrequest)
        wait_cnt <= wait_cnt + 1'b1;
      if (busy_abort)
        fault_q <= 1'b1;
    end
  end
`else
  assign busy_abort = 1'b0;
  assign fault      = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    clk_enable    = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    case (state)
      FETCH: begin
        mem_read    = 1'b1;
        mem_address = instr_address;
        if (!mem_waitrequest)
          state_nxt = (data_read || data_write) ? DATA : RUN;
      end
      DATA: begin
        // A simultaneous read and write request is served as a store.
        if (data_write) begin
          mem_write     = 1'b1;
          mem_address   = data_address;
          mem_writedata = data_writedata;
        end else if (data_read) begin
          mem_read    = 1'b1;
          mem_address = data_address;
        end
        if (!mem_waitrequest)
          state_nxt = RUN;
      end
      RUN: begin
        clk_enable = 1'b1;
        state_nxt  = active ? FETCH : HALT;
      end
      default: ;
    endcase
    if (busy_abort)
      state_nxt = HALT;
    // Reset must drop the strobes at once, even though the state resets to FETCH.
    if (!reset) begin
      clk_enable    = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_address   = '0;
      mem_writedata = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= FETCH;
      instr_readdata <= '0;
      data_readdata  <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && !mem_waitrequest)
        instr_readdata <= mem_readdata;
      if (state == DATA && data_read && !data_write && !mem_waitrequest)
        data_readdata <= mem_readdata;
    end
  end

endmodule

// File: doc/mips_mem_arbiter.md
# mips_mem_arbiter

- Shares one single-port unified memory between the `mips_cpu_harvard` instruction and data ports.
- Sequences each CPU cycle as an instruction fetch, an optional data access, then a one-cycle `clk_enable` pulse that lets the CPU commit.
- Sits between the CPU and the memory model/bus.
- Stalls the CPU, by holding `clk_enable` low, for as long as memory is busy.

## Interface
- `WAIT_LIMIT`, default 16: maximum consecutive `mem_waitrequest` cycles tolerated per transaction when `ARB_TIMEOUT_EN` is defined.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `active` in 1: CPU running flag; 0 means halted.
- `instr_address` in 32: CPU fetch byte address.
- `instr_readdata` out 32: registered fetched instruction.
- `data_address` in 32: CPU data byte address.
- `data_write` in 1: CPU store request.
- `data_read` in 1: CPU load request.
- `data_writedata` in 32: store data.
- `data_readdata` out 32: registered load data.
- `clk_enable` out 1: CPU commit enable.
- `mem_address` out 32: memory byte address.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `mem_writedata` out 32: memory write data.
- `mem_readdata` in 32: memory read data, valid in any cycle with `mem_read`=1 and `mem_waitrequest`=0.
- `mem_waitrequest` in 1: memory busy; the current transaction is held while this is high.
- `fault` out 1: sticky timeout flag.

## Operation
- **States and transitions**
  - FETCH: drive `mem_address`=`instr_address`, `mem_read`=1. On an edge with `mem_waitrequest`=0, capture `mem_readdata` into `instr_readdata`. Go to DATA if `data_read|data_write`, else RUN.
  - DATA: drive `mem_address`=`data_address`.
    - Store: `mem_write`=1, `mem_writedata`=`data_writedata`.
    - Load: `mem_read`=1.
    - On an edge with `mem_waitrequest`=0, a load captures `mem_readdata` into `data_readdata`. Go to RUN.
  - RUN: `clk_enable`=1 for exactly one cycle with no memory strobes. Go to FETCH if `active`=1, else HALT.
  - HALT: all strobes 0, `clk_enable`=0. Stays in HALT until reset.
- **Output decoding**
  - `mem_*` and `clk_enable` are combinational decodes of the state register and the CPU ports.
  - `mem_address`=0 and `mem_writedata`=0 whenever no strobe is active.
- **Request rules**
  - `data_read` and `data_write` both high: treated as a store; `data_readdata` is unchanged.
  - The DATA decision samples `data_read`/`data_write` on the edge that leaves FETCH. The CPU holds them stable while `clk_enable`=0.
  - Addresses are passed through unmodified; misaligned addresses are forwarded as-is.
- **Held registers**
  - `instr_readdata` and `data_readdata` hold their values until overwritten by a completed transaction.
  - The CPU sees them stable through RUN.
- **Reset values** (reset low): state FETCH; `instr_readdata`=0, `data_readdata`=0, `fault`=0, `clk_enable`=0, `mem_read`=0, `mem_write`=0, `mem_address`=0, `mem_writedata`=0.
- **Reset mid-transaction**: strobes drop immediately and asynchronously. The transaction is abandoned with no capture.
- **After reset release**: FETCH begins on the first rising edge with `reset`=1.

## Timing
- **Zero-wait memory**
  - Without a data access: 2 cycles per instruction (FETCH, RUN).
  - With a load or store: 3 cycles per instruction (FETCH, DATA, RUN).
- Each `mem_waitrequest`=1 cycle adds one cycle to the current state. Strobes, address and write data are held constant while waiting.
- Read data is captured on the completing edge and is visible on `instr_readdata`/`data_readdata` in the following cycle.
- **`clk_enable`**
  - Never high in two consecutive cycles.
  - Never high while any memory strobe is high.
- **`active`**
  - Sampled only on the RUN exit edge.
  - Deasserting it mid-FETCH/DATA still completes the instruction.

## Configuration
- **`ARB_TIMEOUT_EN` defined**
  - A wait counter, width `$clog2(WAIT_LIMIT+1)`, counts consecutive waitrequest cycles in FETCH/DATA and clears on state change.
  - On reaching `WAIT_LIMIT`, the transaction is abandoned: no capture, `fault` is set, and the next state is HALT.
  - `fault` stays set until reset.
- **Not defined**
  - No counter; the arbiter waits indefinitely.
  - `fault` is tied to 0.

## Test plan
- **Zero-wait ALU instruction**: `instr_readdata` model returns `32'h2403FF0F` for address `32'hBFC00000`; `data_read`=`data_write`=0 -> `mem_read` high for 1 cycle, `clk_enable` pulses every 2nd cycle, `instr_readdata`=`32'h2403FF0F`.
- **Load**: `data_read`=1, `data_address`=`32'h00001000`, memory word `32'h0000F000` -> sequence FETCH, DATA, RUN; `data_readdata`=`32'h0000F000`; `clk_enable` every 3rd cycle.
- **Store with waits**: `data_write`=1, `data_writedata`=`32'hDEADBEEF`, `mem_waitrequest` high for 2 cycles in DATA -> `mem_write`/`mem_address`/`mem_writedata` held 3 cycles, 5 cycles per instruction, memory updated once.
- **Halt**: `active` falls during FETCH -> instruction completes, one RUN pulse, then HALT with `clk_enable`=0 and no strobes for 20 cycles.
- **Reset mid-DATA**: `reset` low during a waited load -> strobes 0 within the same cycle, `data_readdata`=0; after release, FETCH on the first edge.
- **Timeout** (`ARB_TIMEOUT_EN`, `WAIT_LIMIT`=4): `mem_waitrequest` stuck high in FETCH -> `fault`=1 after 4 wait cycles, HALT, `clk_enable` never pulses; without the macro, no fault and the arbiter remains in FETCH.
